// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for seq_alu and its iterative mul/div unit.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the opcodes handled by the iterative multiply/divide unit.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// hi holds the partial product high half / remainder, lo the multiplier / quotient.
// The result port presents the outcome of the step in progress, so the final
// iteration and the capture by the parent happen on the same clock edge.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_is_div,
  input  logic             hi_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             hsel_q, hsel_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  // One multiply or divide iteration computed from the current registers.
  // A zero divisor always subtracts, giving an all-ones quotient and remainder = a.
  always_comb begin
    mul_add   = lo_q[0] ? b_q : '0;
    mul_sum   = {1'b0, hi_q} + {1'b0, mul_add};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = (div_shift >= {1'b0, b_q});
    if (div_q) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Load on start, then iterate until the counter reaches 1.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    hsel_d = hsel_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    if (start && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = CW'(WIDTH);
      div_d  = op_is_div;
      hsel_d = hi_sel;
      hi_d   = '0;
      lo_d   = a;
      b_d    = b;
    end else if (busy_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // Iteration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      hsel_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      hsel_q <= hsel_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
    end
  end

  assign busy   = busy_q;
  assign done   = busy_q && (cnt_q == CW'(1));
  assign result = hsel_q ? step_hi : step_lo;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle ops finish with latency 1,
// multiply/divide ops go through muldiv_iter and finish with latency WIDTH+1.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter bit          ENABLE_MULDIV = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_zero_q, out_zero_d;

  logic             accept;
  logic             use_md;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_y;
  logic             md_busy, md_done;
  logic [WIDTH-1:0] md_result;

  assign accept = (state_q == ST_IDLE) && in_valid;
  assign use_md = ENABLE_MULDIV && is_muldiv(in_op);
  assign shamt  = in_b[SHW-1:0];

  generate
    if (ENABLE_MULDIV) begin : g_md
      muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && use_md),
        .op_is_div ((in_op == OP_DIVU) || (in_op == OP_REMU)),
        .hi_sel    ((in_op == OP_MULHU) || (in_op == OP_REMU)),
        .a         (in_a),
        .b         (in_b),
        .busy      (md_busy),
        .done      (md_done),
        .result    (md_result)
      );
    end else begin : g_no_md
      assign md_busy   = 1'b0;
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  // Single-cycle datapath; mul/div opcodes fall to zero when the unit is absent.
  always_comb begin
    alu_y = '0;
    case (in_op)
      OP_ADD:  alu_y = in_a + in_b;
      OP_SUB:  alu_y = in_a - in_b;
      OP_AND:  alu_y = in_a & in_b;
      OP_OR:   alu_y = in_a | in_b;
      OP_XOR:  alu_y = in_a ^ in_b;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_SLL:  alu_y = in_a << shamt;
      OP_SRL:  alu_y = in_a >> shamt;
      OP_SRA:  alu_y = $unsigned($signed(in_a) >>> shamt);
      default: alu_y = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; BUSY falls back to IDLE if the unit ever idles without finishing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = use_md ? ST_BUSY : ST_DONE;
      ST_BUSY: begin
        if (md_done) begin
          state_d = ST_DONE;
        end else if (!md_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Result capture: on accept for single-cycle ops, on the final iteration otherwise.
  always_comb begin
    out_y_d    = out_y_q;
    out_zero_d = out_zero_q;
    if (accept && !use_md) begin
      out_y_d    = alu_y;
      out_zero_d = (alu_y == '0);
    end else if ((state_q == ST_BUSY) && md_done) begin
      out_y_d    = md_result;
      out_zero_d = (md_result == '0);
    end
  end

  // Result registers, held stable while waiting for out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_y_q    <= '0;
      out_zero_q <= 1'b0;
    end else begin
      out_y_q    <= out_y_d;
      out_zero_q <= out_zero_d;
    end
  end

  assign out_y    = out_y_q;
  assign out_zero = out_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: dut0 has the mul/div unit, dut1 is built without it.
module tb_seq_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, out_zero0;
  logic [31:0] in_a0, in_b0, out_y0;
  logic [3:0]  in_op0;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_zero1;
  logic [31:0] in_a1, in_b1, out_y1;
  logic [3:0]  in_op1;

  seq_alu #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a0), .in_b(in_b0), .in_op(in_op0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_y(out_y0), .out_zero(out_zero0)
  );

  seq_alu #(.WIDTH(32), .ENABLE_MULDIV(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_op(in_op1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_y(out_y1), .out_zero(out_zero1)
  );

  typedef struct {
    logic [31:0] y;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   seen[2];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, wanted %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented result against the head of the queue.
  task automatic mon(input int d, input logic ov, input logic [31:0] y, input logic z,
                     input logic ordy);
    exp_t e;
    int   n;
    if (ov !== 1'b1) return;
    n = (d == 0) ? q0.size() : q1.size();
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL dut%0d unexpected_result: got out_valid=1 y=%h, wanted no result", d, y);
      return;
    end
    if (d == 0) e = q0[0];
    else        e = q1[0];
    if (y !== e.y || z !== (e.y == 32'd0)) begin
      errors++;
      $display("FAIL dut%0d result: got y=%h zero=%b, wanted y=%h zero=%b",
               d, y, z, e.y, (e.y == 32'd0));
    end
    if (!seen[d]) begin
      seen[d] = 1'b1;
      checks++;
      if (cyc - e.acc != e.lat) begin
        errors++;
        $display("FAIL dut%0d latency: got %0d, wanted %0d", d, cyc - e.acc, e.lat);
      end
    end
    if (ordy === 1'b1) begin
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
      seen[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      mon(0, out_valid0, out_y0, out_zero0, out_ready0);
      mon(1, out_valid1, out_y1, out_zero1, out_ready1);
    end
  end

  // Present one op when the DUT is ready; push the expectation; scramble operands after.
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] y, input int lat);
    exp_t e;
    int   g = 0;
    while (((d == 0) ? in_ready0 : in_ready1) !== 1'b1) begin
      @(posedge clk); #1;
      g++;
      if (g > 200) begin
        checks++;
        errors++;
        $display("FAIL dut%0d in_ready_timeout: got in_ready=0, wanted 1 within 200 cycles", d);
        return;
      end
    end
    e.y   = y;
    e.lat = lat;
    e.acc = cyc;
    if (d == 0) begin
      in_a0 = a; in_b0 = b; in_op0 = op; in_valid0 = 1'b1;
      q0.push_back(e);
    end else begin
      in_a1 = a; in_b1 = b; in_op1 = op; in_valid1 = 1'b1;
      q1.push_back(e);
    end
    @(posedge clk); #1;
    if (d == 0) begin
      in_valid0 = 1'b0; in_a0 = $urandom; in_b0 = $urandom;
    end else begin
      in_valid1 = 1'b0; in_a1 = $urandom; in_b1 = $urandom;
    end
  endtask

  task automatic drain(input int d);
    int g = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0) begin
      @(posedge clk); #1;
      g++;
      if (g > 100) begin
        checks++;
        errors++;
        $display("FAIL dut%0d drain_timeout: got %0d pending results, wanted 0", d,
                 (d == 0) ? q0.size() : q1.size());
        if (d == 0) q0.delete();
        else        q1.delete();
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid0 = 1'b0; in_a0 = '0; in_b0 = '0; in_op0 = OP_ADD; out_ready0 = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_op1 = OP_ADD; out_ready1 = 1'b1;
    #1;
    chk1("reset_out_valid", out_valid0, 1'b0);
    chk1("reset_in_ready", in_ready0, 1'b1);
    chk32("reset_out_y", out_y0, 32'h0);
    chk1("reset_out_zero", out_zero0, 1'b0);
    chk1("reset_out_valid_nomd", out_valid1, 1'b0);
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    // single-cycle ops
    issue(0, 32'hFFFFFFFF, 32'h1,        OP_ADD,  32'h0,        1);
    issue(0, 32'h80000000, 32'h1,        OP_SLT,  32'h1,        1);
    issue(0, 32'h80000000, 32'h1,        OP_SLTU, 32'h0,        1);
    issue(0, 32'h5,        32'h7,        OP_SUB,  32'hFFFFFFFE, 1);
    issue(0, 32'hF0F0F0F0, 32'h0FF00FF0, OP_AND,  32'h00F000F0, 1);
    issue(0, 32'hF0F0F0F0, 32'h0FF00FF0, OP_OR,   32'hFFF0FFF0, 1);
    issue(0, 32'hF0F0F0F0, 32'h0FF00FF0, OP_XOR,  32'hFF00FF00, 1);
    issue(0, 32'h80000000, 32'h24,       OP_SRA,  32'hF8000000, 1);
    issue(0, 32'h80000000, 32'h24,       OP_SRL,  32'h08000000, 1);
    issue(0, 32'h1,        32'h1F,       OP_SLL,  32'h80000000, 1);
    issue(0, 32'h12345678, 32'h9,        4'b1110, 32'h0,        1);
    issue(0, 32'h12345678, 32'h9,        4'b1111, 32'h0,        1);
    drain(0);

    // multiply: in_ready must stay low and a held in_valid must be ignored
    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_MUL, 32'h1, 33);
    for (int i = 0; i < 30; i++) begin
      chk1("busy_in_ready", in_ready0, 1'b0);
      in_valid0 = (i < 20);
      in_op0    = OP_ADD;
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0;
    drain(0);
    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_MULHU, 32'hFFFFFFFE, 33);
    issue(0, 32'h00010000, 32'h00010000, OP_MUL,   32'h0,        33);
    issue(0, 32'h00010000, 32'h00010000, OP_MULHU, 32'h1,        33);

    // divide, including divide by zero
    issue(0, 32'd100,      32'd7, OP_DIVU, 32'd14,       33);
    issue(0, 32'd100,      32'd7, OP_REMU, 32'd2,        33);
    issue(0, 32'h12345678, 32'd0, OP_DIVU, 32'hFFFFFFFF, 33);
    issue(0, 32'd5,        32'd0, OP_REMU, 32'd5,        33);
    drain(0);

    // backpressure: result held, in_valid ignored, IDLE one cycle after out_ready
    out_ready0 = 1'b0;
    issue(0, 32'h12345678, 32'h0F0F0F0F, OP_XOR, 32'h1D3B5977, 1);
    in_valid0 = 1'b1; in_op0 = OP_ADD; in_a0 = 32'h1; in_b0 = 32'h1;
    for (int i = 0; i < 5; i++) begin
      chk1("stall_in_ready", in_ready0, 1'b0);
      chk1("stall_out_valid", out_valid0, 1'b1);
      @(posedge clk); #1;
    end
    in_valid0  = 1'b0;
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    chk1("idle_after_out_ready", in_ready0, 1'b1);
    chk1("valid_drop_after_out_ready", out_valid0, 1'b0);

    // asynchronous reset in the middle of a divide
    issue(0, 32'd100, 32'd7, OP_DIVU, 32'd14, 33);
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk1("midop_reset_out_valid", out_valid0, 1'b0);
    chk1("midop_reset_in_ready", in_ready0, 1'b1);
    chk32("midop_reset_out_y", out_y0, 32'h0);
    q0.delete();
    seen[0] = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    chk1("post_reset_in_ready", in_ready0, 1'b1);
    issue(0, 32'd2, 32'd3, OP_ADD, 32'd5, 1);
    drain(0);
    repeat (40) @(posedge clk);
    #1;

    // build without mul/div: those opcodes return 0 in one cycle
    issue(1, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_MUL,  32'h0, 1);
    issue(1, 32'd100,      32'd7,        OP_DIVU, 32'h0, 1);
    issue(1, 32'd5,        32'd0,        OP_REMU, 32'h0, 1);
    issue(1, 32'd1,        32'd2,        OP_ADD,  32'd3, 1);
    drain(1);
    repeat (5) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
